// File: rtl/gsim_param.sv
// gsim_param -- Gauss-Seidel solver for a banded symmetric Toeplitz system.
//
// The matrix has 20 on the diagonal, -13 at +/-1, +6 at +/-2 and -1 at +/-3.
// A run loads b[0..N-1], then runs iter sweeps of Gauss-Seidel starting from
// x = 0, then streams x[0..N-1] as signed fixed point with FRAC fractional bits.
//
// Optional feature: define GSIM_CONV_EN to stop early once the largest update
// of a sweep is within CONV_TH LSBs. When it is undefined the core always runs
// exactly iter sweeps and conv_flag is tied low.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_en      b_in valid
//   in_ready   core accepts b_in (IDLE and LOAD only)
//   b_in       b element, index 0 first
//   iter_in    sweep count, sampled together with b[0]
//   out_valid  x_out valid (registered)
//   x_out      x element, index 0 first (registered)
//   out_last   marks x[N-1] (registered)
//   conv_flag  high on every output beat of a run that stopped early
module gsim_param #(
   parameter int N       = 16,
   parameter int B_W     = 16,
   parameter int X_W     = 32,
   parameter int FRAC    = 16,
   parameter int CONV_TH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_en,
   output logic           in_ready,
   input  logic [B_W-1:0] b_in,
   input  logic [7:0]     iter_in,
   output logic           out_valid,
   output logic [X_W-1:0] x_out,
   output logic           out_last,
   output logic           conv_flag
);

   localparam int IDX_W = $clog2(N);
   localparam int NW    = X_W + 6;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_THETA     = 3'd2;
   localparam logic [2:0] S_DIV       = 3'd3;
   localparam logic [2:0] S_WB        = 3'd4;
   localparam logic [2:0] S_SWEEP_END = 3'd5;
   localparam logic [2:0] S_SEND      = 3'd6;

   localparam logic signed [NW-1:0] C1  = NW'(1);
   localparam logic signed [NW-1:0] C6  = NW'(6);
   localparam logic signed [NW-1:0] C10 = NW'(10);
   localparam logic signed [NW-1:0] C13 = NW'(13);
   localparam logic signed [NW-1:0] C20 = NW'(20);
   localparam logic signed [NW-1:0] SAT_HI = {{(NW-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
   localparam logic signed [NW-1:0] SAT_LO = {{(NW-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

   if (N < 7 || N > 64 || CONV_TH < 0) begin : g_param_check
      $error("gsim_param: N must be 7..64 and CONV_TH non-negative");
   end

   logic [2:0]            state_reg;
   logic [IDX_W-1:0]      idx_reg;      // load / send element index
   logic [IDX_W-1:0]      i_reg;        // unknown being updated
   logic [7:0]            k_reg;        // completed sweeps
   logic [7:0]            iter_reg;
   logic                  in_ready_reg;
   logic                  out_valid_reg;
   logic [X_W-1:0]        x_out_reg;
   logic                  out_last_reg;
   logic signed [NW-1:0]  num_reg;
   logic signed [NW-1:0]  q_reg;

   logic signed [B_W-1:0] b_mem [N];
   logic signed [X_W-1:0] x_mem [N];

   logic                  accept;
   logic [7:0]            k_inc;
   logic                  stop_early;
   logic                  sweep_done;
   logic signed [NW-1:0]  b_ext;
   logic signed [NW-1:0]  num_next;
   logic signed [NW-1:0]  t_val;
   logic signed [NW-1:0]  q_trunc;
   logic signed [NW-1:0]  q_rem;
   logic signed [NW-1:0]  q_next;
   logic signed [X_W-1:0] q_sat;

   assign accept     = in_en & in_ready_reg;
   assign k_inc      = k_reg + 8'd1;
   assign sweep_done = (k_inc == iter_reg) || stop_early;

   // Symmetric neighbour pairs x[i-d] + x[i+d]; out-of-range taps read as 0.
   genvar gi;
   for (gi = 1; gi <= 3; gi++) begin : g_tap
      logic signed [X_W-1:0] lo;
      logic signed [X_W-1:0] hi;
      logic signed [NW-1:0]  pair;
      always_comb begin
         lo = '0;
         hi = '0;
         if ({1'b0, i_reg} >= (IDX_W+1)'(gi))
            lo = x_mem[i_reg - IDX_W'(gi)];
         if (({1'b0, i_reg} + (IDX_W+1)'(gi)) < (IDX_W+1)'(N))
            hi = x_mem[i_reg + IDX_W'(gi)];
      end
      assign pair = NW'(lo) + NW'(hi);
   end

   always_comb begin
      b_ext    = NW'(b_mem[i_reg]);
      num_next = (b_ext <<< FRAC) + C13 * g_tap[1].pair - C6 * g_tap[2].pair
                 + g_tap[3].pair;
   end

   // Round-to-nearest division by 20: floor((num + 10) / 20). The native
   // operator truncates toward zero, so negative inexact quotients step down.
   always_comb begin
      t_val   = num_reg + C10;
      q_trunc = t_val / C20;
      q_rem   = t_val % C20;
      q_next  = q_trunc;
      if (t_val[NW-1] && (q_rem != '0))
         q_next = q_trunc - C1;
   end

   always_comb begin
      if (q_reg > SAT_HI)
         q_sat = SAT_HI[X_W-1:0];
      else if (q_reg < SAT_LO)
         q_sat = SAT_LO[X_W-1:0];
      else
         q_sat = q_reg[X_W-1:0];
   end

   // Storage arrays carry no reset: x is cleared when a run starts, b is
   // fully rewritten before it is read.
   always_ff @(posedge clk) begin
      if (accept)
         b_mem[idx_reg] <= $signed(b_in);
   end

   always_ff @(posedge clk) begin
      if (state_reg == S_IDLE && accept) begin
         for (int j = 0; j < N; j++)
            x_mem[j] <= '0;
      end else if (state_reg == S_WB) begin
         x_mem[i_reg] <= q_sat;
      end
   end

`ifdef GSIM_CONV_EN
   logic signed [X_W:0] diff;
   logic [X_W:0]        diff_abs;
   logic [X_W:0]        d_max_reg;
   logic                conv_reg;

   always_comb begin
      diff     = $signed({q_sat[X_W-1], q_sat}) - $signed({x_mem[i_reg][X_W-1], x_mem[i_reg]});
      diff_abs = diff[X_W] ? -diff : diff;
   end

   // Early stop only counts when sweeps remain; a run reaching iter is normal.
   assign stop_early = (d_max_reg <= (X_W+1)'(CONV_TH)) && (k_inc < iter_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_max_reg <= '0;
         conv_reg  <= 1'b0;
      end else begin
         if (state_reg == S_SWEEP_END || (state_reg == S_LOAD && accept))
            d_max_reg <= '0;
         else if (state_reg == S_WB && diff_abs > d_max_reg)
            d_max_reg <= diff_abs;

         if (state_reg == S_SWEEP_END && sweep_done)
            conv_reg <= stop_early;
         else if (state_reg == S_SEND && idx_reg == IDX_W'(N-1))
            conv_reg <= 1'b0;
      end
   end

   assign conv_flag = conv_reg;
`else
   assign stop_early = 1'b0;
   assign conv_flag  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         i_reg         <= '0;
         k_reg         <= '0;
         iter_reg      <= '0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         x_out_reg     <= '0;
         out_last_reg  <= 1'b0;
         num_reg       <= '0;
         q_reg         <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  iter_reg  <= iter_in;
                  idx_reg   <= IDX_W'(1);
                  state_reg <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (idx_reg == IDX_W'(N-1)) begin
                     in_ready_reg <= 1'b0;
                     idx_reg      <= '0;
                     i_reg        <= '0;
                     k_reg        <= '0;
                     if (iter_reg == 8'd0) begin
                        state_reg     <= S_SEND;
                        out_valid_reg <= 1'b1;
                        x_out_reg     <= x_mem[0];
                        out_last_reg  <= 1'b0;
                     end else begin
                        state_reg <= S_THETA;
                     end
                  end else begin
                     idx_reg <= idx_reg + IDX_W'(1);
                  end
               end
            end
            S_THETA: begin
               num_reg   <= num_next;
               state_reg <= S_DIV;
            end
            S_DIV: begin
               q_reg     <= q_next;
               state_reg <= S_WB;
            end
            S_WB: begin
               if (i_reg == IDX_W'(N-1)) begin
                  i_reg     <= '0;
                  state_reg <= S_SWEEP_END;
               end else begin
                  i_reg     <= i_reg + IDX_W'(1);
                  state_reg <= S_THETA;
               end
            end
            S_SWEEP_END: begin
               k_reg <= k_inc;
               if (sweep_done) begin
                  state_reg     <= S_SEND;
                  idx_reg       <= '0;
                  out_valid_reg <= 1'b1;
                  x_out_reg     <= x_mem[0];
                  out_last_reg  <= 1'b0;
               end else begin
                  state_reg <= S_THETA;
               end
            end
            S_SEND: begin
               if (idx_reg == IDX_W'(N-1)) begin
                  out_valid_reg <= 1'b0;
                  x_out_reg     <= '0;
                  out_last_reg  <= 1'b0;
                  idx_reg       <= '0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= S_IDLE;
               end else begin
                  idx_reg      <= idx_reg + IDX_W'(1);
                  x_out_reg    <= x_mem[idx_reg + IDX_W'(1)];
                  out_last_reg <= ((idx_reg + IDX_W'(1)) == IDX_W'(N-1));
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign x_out     = x_out_reg;
   assign out_last  = out_last_reg;

endmodule
